// File: rtl/fp32_div_seq.sv
// fp32_div_seq: sequential IEEE-754 single-precision divider, radix-2 restoring, one quotient bit per clock, truncating.
// Define FPDIV_EXP_CLAMP_EN to saturate the result exponent (inf / zero) instead of wrapping it mod 256.
module fp32_div_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_NORM   = 2'd2;

    // Count value of the 25th (final) quotient-bit iteration
    localparam logic [4:0] LAST_STEP = 5'd24;

    // Zero test on {exp, mant}; the sign bit is deliberately excluded
    function automatic logic is_zero(input logic [30:0] mag);
        return (mag == 31'd0);
    endfunction

    function automatic logic [31:0] inf_word(input logic sign);
        return {sign, 8'hFF, 23'd0};
    endfunction

    logic [1:0]  state_r,  state_nxt_s;
    logic        sign_r,   sign_nxt_s;
    logic [7:0]  ea_r,     ea_nxt_s;
    logic [7:0]  eb_r,     eb_nxt_s;
    logic [23:0] mb_r,     mb_nxt_s;
    logic [25:0] rem_r,    rem_nxt_s;
    logic [24:0] q_r,      q_nxt_s;
    logic [4:0]  count_r,  count_nxt_s;
    logic [31:0] result_r, result_nxt_s;
    logic        done_r,   done_nxt_s;

    logic [25:0] mb_ext_s;
    logic [25:0] rem_diff_s;
    logic [22:0] mant_s;
    logic [31:0] norm_word_s;

`ifdef FPDIV_EXP_CLAMP_EN
    logic signed [9:0] exp_raw_s;
    logic signed [9:0] exp_adj_s;
`else
    logic [7:0] exp_raw_s;
    logic [7:0] exp_adj_s;
`endif

    assign mb_ext_s   = {2'b00, mb_r};
    assign rem_diff_s = rem_r - mb_ext_s;

    // Normalisation: quotient lies in [2^23, 2^25), so at most one right step
    always_comb begin
        mant_s      = 23'd0;
        exp_raw_s   = '0;
        exp_adj_s   = '0;
        norm_word_s = 32'd0;
`ifdef FPDIV_EXP_CLAMP_EN
        exp_raw_s = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r}) + 10'sd127;
        if (q_r[24]) begin
            mant_s    = q_r[23:1];
            exp_adj_s = exp_raw_s;
        end else begin
            mant_s    = q_r[22:0];
            exp_adj_s = exp_raw_s - 10'sd1;
        end
        if (exp_adj_s >= 10'sd255) begin
            norm_word_s = inf_word(sign_r);
        end else if (exp_adj_s <= 10'sd0) begin
            norm_word_s = 32'h0000_0000;
        end else begin
            norm_word_s = {sign_r, exp_adj_s[7:0], mant_s};
        end
`else
        exp_raw_s = ea_r - eb_r + 8'd127;
        if (q_r[24]) begin
            mant_s    = q_r[23:1];
            exp_adj_s = exp_raw_s;
        end else begin
            mant_s    = q_r[22:0];
            exp_adj_s = exp_raw_s - 8'd1;
        end
        norm_word_s = {sign_r, exp_adj_s, mant_s};
`endif
    end

    // Next-state and datapath control for IDLE / DIVIDE / NORM
    always_comb begin
        state_nxt_s  = state_r;
        sign_nxt_s   = sign_r;
        ea_nxt_s     = ea_r;
        eb_nxt_s     = eb_r;
        mb_nxt_s     = mb_r;
        rem_nxt_s    = rem_r;
        q_nxt_s      = q_r;
        count_nxt_s  = count_r;
        result_nxt_s = result_r;
        done_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    if (is_zero(dataa[30:0])) begin
                        result_nxt_s = 32'h0000_0000;
                        done_nxt_s   = 1'b1;
                    end else if (is_zero(datab[30:0])) begin
                        result_nxt_s = inf_word(dataa[31] ^ datab[31]);
                        done_nxt_s   = 1'b1;
                    end else begin
                        sign_nxt_s  = dataa[31] ^ datab[31];
                        ea_nxt_s    = dataa[30:23];
                        eb_nxt_s    = datab[30:23];
                        mb_nxt_s    = {1'b1, datab[22:0]};
                        rem_nxt_s   = {2'b01, dataa[22:0]};
                        q_nxt_s     = 25'd0;
                        count_nxt_s = 5'd0;
                        state_nxt_s = ST_DIVIDE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                // rem < 2*mb always holds, so the shifted remainder never overflows 26 bits
                if (rem_r >= mb_ext_s) begin
                    q_nxt_s   = {q_r[23:0], 1'b1};
                    rem_nxt_s = rem_diff_s << 1;
                end else begin
                    q_nxt_s   = {q_r[23:0], 1'b0};
                    rem_nxt_s = rem_r << 1;
                end
                count_nxt_s = count_r + 5'd1;
                if (count_r == LAST_STEP) begin
                    state_nxt_s = ST_NORM;
                end else begin
                    state_nxt_s = ST_DIVIDE;
                end
            end
            ST_NORM: begin
                result_nxt_s = norm_word_s;
                done_nxt_s   = 1'b1;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight without a done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            sign_r   <= 1'b0;
            ea_r     <= 8'd0;
            eb_r     <= 8'd0;
            mb_r     <= 24'd0;
            rem_r    <= 26'd0;
            q_r      <= 25'd0;
            count_r  <= 5'd0;
            result_r <= 32'd0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sign_r   <= sign_nxt_s;
            ea_r     <= ea_nxt_s;
            eb_r     <= eb_nxt_s;
            mb_r     <= mb_nxt_s;
            rem_r    <= rem_nxt_s;
            q_r      <= q_nxt_s;
            count_r  <= count_nxt_s;
            result_r <= result_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign result = result_r;
    assign done   = done_r;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed self-checking bench for fp32_div_seq: latency, zero paths, exponent wrap/clamp, held enable, reset abort.
module tb_fp32_div_seq;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic [31:0] result;
    logic        done;

    int compared   = 0;
    int mismatched = 0;

    fp32_div_seq dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .dataa  (dataa),
        .datab  (datab),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // Start one op at edge k, check done every cycle up to the expected completion, then the result
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int lat);
        @(negedge clk);
        dataa  = a;
        datab  = b;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        dataa  = 32'h1234_5678;
        datab  = 32'h0000_0000;
        for (int i = 0; i <= lat; i++) begin
            if (i > 0) @(negedge clk);
            check1($sformatf("%s done@%0d", tag, i), done, (i == lat));
        end
        check32({tag, " result"}, result, exp_res);
        @(negedge clk);
        check1({tag, " done after"}, done, 1'b0);
        check32({tag, " result held"}, result, exp_res);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        dataa  = 32'd0;
        datab  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset result", result, 32'h0000_0000);
        check1("reset done", done, 1'b0);
        reset = 1'b0;

        run_op("6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);
        run_op("1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26);
        run_op("-1/0.5", 32'hBF80_0000, 32'h3F00_0000, 32'hC000_0000, 26);
        run_op("0/2", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("1/-0", 32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 0);
        run_op("-0/0 prio", 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 0);
`ifdef FPDIV_EXP_CLAMP_EN
        run_op("big/small", 32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 26);
        run_op("small/big", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 26);
        run_op("denorm/1", 32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 26);
`else
        run_op("big/small", 32'h7F00_0000, 32'h0080_0000, 32'h3E00_0000, 26);
        run_op("small/big", 32'h0080_0000, 32'h7F00_0000, 32'h4100_0000, 26);
        run_op("denorm/1", 32'h0040_0000, 32'h3F80_0000, 32'h0040_0000, 26);
`endif

        // enable held high for three back-to-back ops; operands disturbed during DIVIDE
        @(negedge clk);
        dataa  = 32'h40C0_0000;
        datab  = 32'h4000_0000;
        enable = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 80; i++) begin
            @(negedge clk);
            check1($sformatf("held done@%0d", i), done, (i == 26 || i == 53 || i == 80));
            if (i == 26) check32("held op1", result, 32'h4040_0000);
            if (i == 53) check32("held op2", result, 32'h3EAA_AAAA);
            if (i == 80) check32("held op3", result, 32'h4000_0000);
            if (i == 1)  begin dataa = 32'h0000_0000; datab = 32'hDEAD_BEEF; end
            if (i == 20) begin dataa = 32'h3F80_0000; datab = 32'h4040_0000; end
            if (i == 30) begin dataa = 32'hCAFE_F00D; datab = 32'h0000_0000; end
            if (i == 45) begin dataa = 32'h4120_0000; datab = 32'h40A0_0000; end
            if (i == 54) enable = 1'b0;
        end
        @(negedge clk);
        check1("held no extra done", done, 1'b0);

        // reset at DIVIDE edge k+10 aborts the op
        @(negedge clk);
        dataa  = 32'h3F80_0000;
        datab  = 32'h4040_0000;
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        enable = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check1("abort done", done, 1'b0);
        check32("abort result", result, 32'h0000_0000);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check1($sformatf("abort quiet@%0d", i), done, 1'b0);
        end
        run_op("6/2 after abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);

        // reset and enable together: reset wins, nothing starts
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        dataa  = 32'h3F80_0000;
        datab  = 32'h4040_0000;
        @(negedge clk);
        reset  = 1'b0;
        enable = 1'b0;
        check32("rst+en result", result, 32'h0000_0000);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check1($sformatf("rst+en quiet@%0d", i), done, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
